// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - framed byte stream to instruction memory loader with checksum
module inst_mem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [16:0] DEPTH_W = 17'(2 ** ADDR_WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]            state, state_nxt;
    logic [7:0]            len_hi;
    logic [15:0]           words_left;
    logic [1:0]            byte_cnt;
    logic [23:0]           asm_word;
    logic [7:0]            chk_acc;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  xfer;
    logic [15:0]           len_rx;

    assign xfer   = byte_valid && byte_ready;
    assign len_rx = {len_hi, byte_data};

    assign cpu_hold   = (state != S_DONE);
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERROR);

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            case (state)
                S_IDLE:   if (byte_data == SYNC_BYTE) state_nxt = S_LEN_HI;
                S_LEN_HI: state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if ({1'b0, len_rx} > DEPTH_W)
                        state_nxt = S_ERROR;
                    else if (len_rx == 16'd0)
                        state_nxt = S_CHECK;
                    else
                        state_nxt = S_DATA;
                end
                S_DATA:   if (byte_cnt == 2'd3 && words_left == 16'd1) state_nxt = S_CHECK;
                S_CHECK:  state_nxt = (byte_data == chk_acc) ? S_DONE : S_ERROR;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            len_hi     <= 8'd0;
            words_left <= 16'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            chk_acc    <= 8'd0;
            wr_addr    <= '0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            state      <= state_nxt;
            // Ready tracks the state being entered so terminal states stop the stream at once
            byte_ready <= (state_nxt != S_DONE) && (state_nxt != S_ERROR);
            mem_we     <= 1'b0;
            if (xfer) begin
                case (state)
                    S_IDLE: begin
                        if (byte_data == SYNC_BYTE) begin
                            chk_acc  <= 8'd0;
                            wr_addr  <= '0;
                            byte_cnt <= 2'd0;
                        end
                    end
                    S_LEN_HI: len_hi <= byte_data;
                    S_LEN_LO: words_left <= len_rx;
                    S_DATA: begin
                        chk_acc  <= chk_acc ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_word <= {asm_word[15:0], byte_data};
                        if (byte_cnt == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_waddr  <= wr_addr;
                            mem_wdata  <= {asm_word, byte_data};
                            words_left <= words_left - 16'd1;
                            // Holding the address on the last word keeps N = DEPTH from wrapping
                            if (words_left != 16'd1)
                                wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - self-checking bench for inst_mem_loader
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int errors = 0;
    int checks = 0;

    logic [7:0]  pay[$];
    logic [3:0]  wa_q[$];
    logic [31:0] wd_q[$];

    typedef struct {
        int n;
        bit bad_chk;
        int garbage;
        bit gaps;
        bit exp_done;
        bit exp_err;
        int exp_writes;
    } vec_t;

    vec_t vecs[7];

    inst_mem_loader #(.ADDR_WIDTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wa_q.push_back(mem_waddr);
            wd_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Reference: word i is payload bytes 4i..4i+3 big-endian at address i
    task automatic run_frame(input string name, input int n, input logic [7:0] chk_byte,
                             input int garbage, input bit gaps, input bit exp_done,
                             input bit exp_err, input int exp_writes);
        logic [7:0] g;
        logic [31:0] w;
        wa_q.delete();
        wd_q.delete();
        for (int i = 0; i < garbage; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, gaps);
        end
        send_byte(8'hA5, gaps);
        send_byte(8'(n >> 8), gaps);
        send_byte(8'(n), gaps);
        if (n <= 16) begin
            for (int i = 0; i < n * 4; i++) send_byte(pay[i], gaps);
            send_byte(chk_byte, gaps);
        end
        check({name, "_done"}, 32'(load_done), 32'(exp_done));
        check({name, "_error"}, 32'(load_error), 32'(exp_err));
        check({name, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({name, "_ready"}, 32'(byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        check({name, "_nwrites"}, 32'(wa_q.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < wa_q.size(); i++) begin
            w = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
            check({name, "_waddr"}, 32'(wa_q[i]), 32'(i));
            check({name, "_wdata"}, wd_q[i], w);
        end
    endtask

    function automatic logic [7:0] xor_pay(input int n);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < n * 4; i++) x ^= pay[i];
        return x;
    endfunction

    task automatic random_payload(input int n);
        pay.delete();
        for (int i = 0; i < n * 4; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [7:0] c;
        vecs[0] = '{2,  1'b0, 0, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{2,  1'b1, 0, 1'b0, 1'b0, 1'b1, 2};
        vecs[2] = '{0,  1'b0, 3, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{17, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{16, 1'b0, 0, 1'b1, 1'b1, 1'b0, 16};
        vecs[5] = '{1,  1'b1, 2, 1'b1, 1'b0, 1'b1, 1};
        vecs[6] = '{5,  1'b0, 2, 1'b1, 1'b1, 1'b0, 5};

        #3;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        do_reset();
        check("post_rst_ready", 32'(byte_ready), 32'd1);

        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
        run_frame("fixed_good", 2, xor_pay(2), 0, 1'b0, 1'b1, 1'b0, 2);
        do_reset();
        run_frame("fixed_bad", 2, 8'h30, 0, 1'b0, 1'b0, 1'b1, 2);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            random_payload(vecs[v].n > 16 ? 0 : vecs[v].n);
            c = xor_pay(vecs[v].n > 16 ? 0 : vecs[v].n);
            if (vecs[v].bad_chk) c = c ^ 8'(1 << $urandom_range(0, 7));
            run_frame($sformatf("vec%0d", v), vecs[v].n, c, vecs[v].garbage, vecs[v].gaps,
                      vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes);
        end

        do_reset();
        random_payload(2);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pay[i], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", 32'(byte_ready), 32'd0);
        check("async_we", 32'(mem_we), 32'd0);
        check("async_waddr", 32'(mem_waddr), 32'd0);
        check("async_wdata", mem_wdata, 32'd0);
        check("async_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        random_payload(1);
        run_frame("after_rst", 1, xor_pay(1), 0, 1'b0, 1'b1, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
